// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: on a miss, issues one read per word of the block, then writes returning words and the tag.
// Latency: first read issued the cycle after the miss is accepted; fill_done pulses one cycle after the final returned word.
// Backpressure: fsm_busy stalls the requester for the whole fill. Memory returns are never stalled (no ready), only counted.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   miss_detected/address     miss request from tag-match logic, sampled only while idle
//   mem_data_valid/in         returning memory words, in request order
//   fsm_busy                  high whenever a fill is in progress (including the done cycle)
//   mem_read_en/addr          one read request per cycle; address forced to 0 when not requesting
//   data_wen/word/out         cache data-array write port
//   tag_wen                   tag/valid write, coincides with the final word write
//   fill_done                 single-cycle completion pulse
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    localparam int BYTES  = DATA_W / 8,
    localparam int WIDX_W = $clog2(WORDS),
    localparam int OFF_W  = $clog2(WORDS * BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              data_wen,
    output logic [WIDX_W-1:0] data_word,
    output logic [DATA_W-1:0] data_out,
    output logic              tag_wen,
    output logic              fill_done
);

    // Word index sits above the byte-in-word bits of the block offset.
    localparam int LSB_W = OFF_W - WIDX_W;
    localparam int CNT_W = WIDX_W + 1;
    localparam logic [CNT_W-1:0] C_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_W-OFF_W-1:0] r_base;
    logic [CNT_W-1:0]        r_issue_cnt;
    logic [CNT_W-1:0]        r_recv_cnt;

    logic                    w_in_fill;
    logic                    w_issue;
    logic                    w_recv;
    logic                    w_last_recv;
    logic [ADDR_W-1:0]       w_req_addr;

    // Block offset bits of the miss address are discarded; the fill always starts at word 0.
    logic                    w_unused_offset;
    assign w_unused_offset = ^miss_address[OFF_W-1:0];

    assign w_in_fill   = (r_state == S_FILL);
    // Issue stops once every word has been requested; the extra counter bit keeps it from wrapping.
    assign w_issue     = w_in_fill && (r_issue_cnt < C_WORDS);
    assign w_recv      = w_in_fill && mem_data_valid;
    assign w_last_recv = w_recv && (r_recv_cnt == C_LAST);
    assign w_req_addr  = {r_base, {OFF_W{1'b0}}}
                       | (ADDR_W'(r_issue_cnt[WIDX_W-1:0]) << LSB_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_detected) begin
                        r_base      <= miss_address[ADDR_W-1:OFF_W];
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Request and return sides advance independently; both may step in one cycle.
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (w_recv) begin
                        r_recv_cnt <= r_recv_cnt + 1'b1;
                    end
                    if (w_last_recv) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state so that an asynchronous reset clears them at once.
    assign fsm_busy    = (r_state != S_IDLE);
    assign mem_read_en = w_issue;
    assign mem_addr    = w_issue ? w_req_addr : '0;
    assign data_wen    = w_recv;
    assign data_word   = w_in_fill ? r_recv_cnt[WIDX_W-1:0] : '0;
    // Pass-through of the memory word, zeroed whenever no write is taking place.
    assign data_out    = w_recv ? mem_data_in : '0;
    assign tag_wen     = w_last_recv;
    assign fill_done   = (r_state == S_DONE);

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Parametrised cache line-fill controller. It replaces the fixed 8-word, 16-bit fill FSM. On a miss it captures the block base address and issues one pipelined memory read per cycle, one per word of the block. It then collects returning words independently of issue, writes each into the cache data array at its word index, and on the final word writes tag/valid and pulses completion. Sits between I-/D-cache tag-match logic and the shared memory port; fsm_busy is the pipeline stall.

Parameters:
ADDR_W, 16, address width in bits (byte addressed)
DATA_W, 16, memory/cache word width in bits; multiple of 8
WORDS, 8, words per cache block; power of 2, >= 2
Derived, not overridable: BYTES = DATA_W/8; WIDX_W = log2(WORDS); OFF_W = log2(WORDS*BYTES)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
miss_detected  in  1  tag-match miss, sampled only in IDLE
miss_address  in  ADDR_W  address that missed; sampled with miss_detected
mem_data_valid  in  1  valid word on mem_data_in this cycle
mem_data_in  in  DATA_W  returning memory word
fsm_busy  out  1  high while state != IDLE
mem_read_en  out  1  read request issued this cycle
mem_addr  out  ADDR_W  read address; 0 when mem_read_en low
data_wen  out  1  write data_out into cache data array
data_word  out  WIDX_W  word index within block for data_wen
data_out  out  DATA_W  word to write (= mem_data_in, combinational pass-through)
tag_wen  out  1  write tag/valid for captured block (with final word)
fill_done  out  1  one-cycle pulse, fill complete

Behaviour:
- Reset (async, any state, including mid-fill): state IDLE; base, issue_cnt, recv_cnt cleared. All outputs 0 while rst is high and after release until a miss is accepted.
- Registers:
  - base[ADDR_W-1:OFF_W], latched from miss_address.
  - issue_cnt, recv_cnt: each WIDX_W+1 bits.
- States: IDLE, FILL, DONE.
- IDLE:
  - miss_detected=1 at an edge: latch base, clear counters, go to FILL.
  - Otherwise stay. mem_data_valid is ignored.
- FILL:
  - Issue side: mem_read_en = (issue_cnt < WORDS). mem_addr = {base, issue_cnt[WIDX_W-1:0], OFF_W-WIDX_W zero bits}. issue_cnt increments each cycle mem_read_en is high.
  - Receive side: data_wen = mem_data_valid. data_word = recv_cnt[WIDX_W-1:0]. recv_cnt increments on each valid.
  - Issue and receive advance independently. Valid may arrive the same cycle a request issues.
  - Words are returned in request order.
- Final word: valid while recv_cnt == WORDS-1 asserts tag_wen together with data_wen. Next state is DONE.
- DONE, one cycle:
  - fill_done=1 and fsm_busy=1; all other outputs 0.
  - Next state IDLE unconditionally.
  - miss_detected is ignored in DONE and FILL. Requester must hold the miss until fsm_busy falls; IDLE then re-samples it.
- Latency:
  - Miss sampled at edge E0 gives first mem_read_en in cycle E0+1.
  - Last request at E0+WORDS.
  - fill_done is one cycle after the final valid.
  - fsm_busy falls two cycles after the final valid edge.
- Boundaries:
  - mem_data_valid in IDLE/DONE: no write, no counter change.
  - Valid before all issues complete: accepted normally.
  - Final valid in the same cycle as the last issue (zero-latency memory): both complete, go to DONE.
  - Counters never wrap within a fill; issue stops at WORDS.
  - Reset mid-fill: no tag_wen or fill_done is produced for the aborted block.

Test Plan:
1. Defaults, memory model latency 4, miss_address=0xABC7 for one cycle:
   - mem_read_en for 8 cycles with mem_addr 0xABC0,0xABC2,...,0xABCE.
   - data_wen with data_word 0..7, tag_wen only with word 7.
   - fill_done one cycle later; fsm_busy high exactly 1+8+4+1 cycles after acceptance.
2. Back-to-back misses 0x1230 then 0x4560 (miss held during busy):
   - Second fill starts the cycle after fsm_busy falls.
   - Addresses 0x4560..0x456E; no interleaving.
3. Memory with irregular valid gaps (1,0,0,1,...):
   - data_word increments only on valid; data_out equals mem_data_in each write.
   - tag_wen coincides with the 8th valid.
4. rst asserted asynchronously after 3 words received:
   - Outputs drop immediately, state IDLE.
   - Later stray valids cause no data_wen.
   - New miss 0x0F00 fills from word 0.
5. Spurious mem_data_valid while IDLE and during DONE -> no data_wen, tag_wen, or counter change.
6. Parameter override DATA_W=32, WORDS=4, ADDR_W=32, miss 0x0000_1234:
   - mem_addr 0x1230,0x1234,0x1238,0x123C.
   - data_word 0..3, tag_wen on word 3.
